// File: rtl/csa_pipe_add32.sv
// rtl/csa_pipe_add32.sv - two-stage pipelined carry-skip adder with valid/ready handshakes
// Stage 1 adds the low LO_W bits; stage 2 adds the high bits using the registered low carry.
module csa_pipe_add32 #(
  parameter int WIDTH = 32,
  parameter int LO_W  = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG    = WIDTH / BLOCK;
  localparam int NG_LO = LO_W / BLOCK;
  localparam int HI_W  = WIDTH - LO_W;

  logic             r_v1;
  logic [LO_W-1:0]  r_lo_sum;
  logic             r_c_lo;
  logic [HI_W-1:0]  r_a_hi;
  logic [HI_W-1:0]  r_b_hi;
  logic             r_v2;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_load1;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_sum_all;
  logic             w_c;
  logic             w_gcin;
  logic             w_p;
  logic             w_c_lo;
  logic             w_c_msb;

  assign w_adv2    = ~r_v2 | out_ready;
  assign w_adv1    = ~r_v1 | w_adv2;
  assign w_load1   = in_valid & w_adv1;
  assign in_ready  = w_adv1;
  assign out_valid = r_v2;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // Low groups see live operands; high groups see the stage-1 registered operands.
  assign w_op_a = {r_a_hi, a[LO_W-1:0]};
  assign w_op_b = {r_b_hi, b[LO_W-1:0]};

  always_comb begin
    w_sum_all = '0;
    w_c       = cin;
    w_gcin    = 1'b0;
    w_p       = 1'b0;
    w_c_lo    = 1'b0;
    w_c_msb   = 1'b0;
    for (int g = 0; g < NG; g++) begin
      // The chain breaks at the stage boundary: high groups start from the registered carry.
      if (g == NG_LO) begin
        w_c_lo = w_c;
        w_c    = r_c_lo;
      end
      w_gcin = w_c;
      w_p    = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        w_sum_all[g*BLOCK+j] = w_op_a[g*BLOCK+j] ^ w_op_b[g*BLOCK+j] ^ w_c;
        if (g*BLOCK+j == WIDTH-1) w_c_msb = w_c;
        w_p = w_p & (w_op_a[g*BLOCK+j] ^ w_op_b[g*BLOCK+j]);
        w_c = (w_op_a[g*BLOCK+j] & w_op_b[g*BLOCK+j]) |
              (w_c & (w_op_a[g*BLOCK+j] ^ w_op_b[g*BLOCK+j]));
      end
      if (w_p) w_c = w_gcin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_lo_sum <= '0;
      r_c_lo   <= 1'b0;
      r_a_hi   <= '0;
      r_b_hi   <= '0;
      r_v2     <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_load1) begin
        r_v1     <= 1'b1;
        r_lo_sum <= w_sum_all[LO_W-1:0];
        r_c_lo   <= w_c_lo;
        r_a_hi   <= a[WIDTH-1:LO_W];
        r_b_hi   <= b[WIDTH-1:LO_W];
      end else if (w_adv1) begin
        r_v1 <= 1'b0;
      end
      if (w_adv2) begin
        r_v2   <= r_v1;
        r_sum  <= {w_sum_all[WIDTH-1:LO_W], r_lo_sum};
        r_cout <= w_c;
        r_ovf  <= w_c_msb ^ w_c;
      end
    end
  end
endmodule

// File: tb/tb_csa_pipe_add32.sv
// tb/tb_csa_pipe_add32.sv - scoreboard bench for csa_pipe_add32
// Driver pushes reference results on acceptance; monitor pops and compares on each transfer.
module tb_csa_pipe_add32;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  logic [33:0] sb[$];
  int          out_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  csa_pipe_add32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition; overflow when like-signed operands give an unlike-signed sum.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {32'd0, c};
    v = (x[31] == y[31]) && (t[31] != x[31]);
    return {t[32], v, t[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: a transfer happens at the next rising edge when out_valid & out_ready.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_output", {30'd0, cout, ovf, sum}, 64'hDEAD);
      end else begin
        chk("result", {30'd0, cout, ovf, sum}, {30'd0, sb.pop_front()});
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    int g = 0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    #1;
    while (!in_ready && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    else sb.push_back(ref_add(ta, tb, tc));
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hold;
    int          acc;
    int          n0;
    logic [34:0] snap;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", {cout, ovf, sum}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);

    // Cross-stage carry plus latency: valid appears after the second edge.
    out_ready = 1'b1;
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    #3;
    chk("lat_valid", out_valid, 1);
    chk("lat_sum", {cout, ovf, sum}, {2'b00, 32'h0001_0000});

    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();

    // Back-to-back stream.
    out_cyc.delete();
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(1)));
    drain();
    chk("stream_count", out_cyc.size(), 8);
    if (out_cyc.size() == 8) chk("stream_consecutive", out_cyc[7] - out_cyc[0], 7);

    // Stall: only two operands fit, outputs frozen.
    hold = 1'b0;
    acc = 0;
    snap = '0;
    for (int it = 0; it < 5; it++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (!hold) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(1));
      end
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        sb.push_back(ref_add(a, b, cin));
        acc++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
      end
      if (it == 2) snap = {out_valid, cout, ovf, sum};
      if (it > 2) chk("stall_stable", {out_valid, cout, ovf, sum}, snap);
    end
    chk("stall_accepts", acc, 2);
    chk("stall_in_ready", in_ready, 0);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_before_rst", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", {cout, ovf, sum}, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    n0 = out_cyc.size();
    repeat (6) @(negedge clk);
    chk("rst_quiet", out_cyc.size() - n0, 0);

    // Randomized traffic with random backpressure.
    hold = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(3) != 0);
        a = pick(); b = pick(); cin = 1'($urandom_range(1));
      end
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(ref_add(a, b, cin));
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
